core_wb_sched: RTL and testbench

CORE_WB_SCHED -- requirements
Module: core_wb_sched

---
 rtl/core_wb_sched_pkg.sv | 14 +
 rtl/core_wb_sched_arb.sv | 51 +++++
 rtl/core_wb_sched.sv | 98 +++++++++
 tb/tb_core_wb_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_wb_sched_pkg.sv
// Shared defaults for the writeback scheduler: datapath width, register index
// width and number of writeback requesters.
package core_wb_sched_pkg;

  localparam int CORE_XLEN        = 32;
  localparam int CORE_RFIDX_WIDTH = 5;
  localparam int CORE_WB_PORTS    = 3;

  // Pointer width for an n-way round-robin; a single requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_wb_sched_arb.sv
// Round-robin arbiter for the writeback requesters. The grant is combinational
// from the requests and the pointer; the pointer moves past the winner.
module core_wb_rr_arb
  import core_wb_sched_pkg::*;
#(
  parameter int N = CORE_WB_PORTS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = ptr_width(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] gidx;
  logic          found;

  // Search from the pointer upward, wrapping at N-1; nothing is granted in reset.
  always_comb begin
    int p;
    gnt_o = '0;
    gidx  = '0;
    found = 1'b0;
    p     = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr_q) + k;
      if (p >= N) p = p - N;
      if (!found && !rst && req_i[p]) begin
        found    = 1'b1;
        gidx     = PW'(p);
        gnt_o[p] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/core_wb_sched.sv
// Writeback scheduler: register scoreboard that stalls hazardous issue, plus a
// round-robin funnel from the writeback requesters into the single regfile write port.
module core_wb_sched
  import core_wb_sched_pkg::*;
#(
  parameter int NPORT = CORE_WB_PORTS,
  parameter int XLEN  = CORE_XLEN,
  parameter int IDXW  = CORE_RFIDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_vld,
  input  logic                  issue_rd_wen,
  input  logic [IDXW-1:0]       issue_rd_idx,
  input  logic [IDXW-1:0]       issue_rs1_idx,
  input  logic [IDXW-1:0]       issue_rs2_idx,
  output logic                  issue_stall,
  input  logic [NPORT-1:0]      wb_vld,
  input  logic [NPORT*IDXW-1:0] wb_idx,
  input  logic [NPORT*XLEN-1:0] wb_dat,
  output logic [NPORT-1:0]      wb_rdy,
  output logic                  rf_wen,
  output logic [IDXW-1:0]       rf_widx,
  output logic [XLEN-1:0]       rf_wdat
);

  localparam int NREG = 1 << IDXW;

  logic [NREG-1:0] pend_q, pend_d;
  logic            rf_wen_q, rf_wen_d;
  logic [IDXW-1:0] rf_widx_q, rf_widx_d;
  logic [XLEN-1:0] rf_wdat_q, rf_wdat_d;

  logic            xfer;
  logic            fire;
  logic [IDXW-1:0] sel_idx;
  logic [XLEN-1:0] sel_dat;

  core_wb_rr_arb #(.N(NPORT)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (wb_vld),
    .gnt_o (wb_rdy)
  );

  assign xfer = |(wb_vld & wb_rdy);

  // Grant is one-hot, so OR-ing the masked lanes selects the winner.
  always_comb begin
    sel_idx = '0;
    sel_dat = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (wb_rdy[i]) begin
        sel_idx = sel_idx | wb_idx[i*IDXW +: IDXW];
        sel_dat = sel_dat | wb_dat[i*XLEN +: XLEN];
      end
    end
  end

  assign issue_stall = ~rst & issue_vld &
                       (pend_q[issue_rs1_idx] | pend_q[issue_rs2_idx] |
                        (issue_rd_wen & pend_q[issue_rd_idx]));
  assign fire        = issue_vld & ~issue_stall & ~rst;

  // x0 transfers are accepted but never reach the regfile.
  always_comb begin
    rf_wen_d  = xfer & (sel_idx != '0);
    rf_widx_d = xfer ? sel_idx : rf_widx_q;
    rf_wdat_d = xfer ? sel_dat : rf_wdat_q;
  end

  // Set is applied after clear so a same-index issue keeps the bit pending.
  always_comb begin
    pend_d = pend_q;
    if (rf_wen_q) pend_d[rf_widx_q] = 1'b0;
    if (fire && issue_rd_wen) pend_d[issue_rd_idx] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      rf_wen_q  <= 1'b0;
      rf_widx_q <= '0;
      rf_wdat_q <= '0;
    end else begin
      pend_q    <= pend_d;
      rf_wen_q  <= rf_wen_d;
      rf_widx_q <= rf_widx_d;
      rf_wdat_q <= rf_wdat_d;
    end
  end

  assign rf_wen  = rf_wen_q;
  assign rf_widx = rf_widx_q;
  assign rf_wdat = rf_wdat_q;

endmodule

// File: tb/tb_core_wb_sched.sv
// Scoreboard bench for core_wb_sched: a reference model predicts grants, stalls
// and regfile writes; a separate monitor pops predicted writes as rf_wen appears.
module tb_core_wb_sched;
  import core_wb_sched_pkg::*;

  localparam int N    = CORE_WB_PORTS;
  localparam int XL   = CORE_XLEN;
  localparam int IW   = CORE_RFIDX_WIDTH;
  localparam int NREG = 1 << IW;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_vld, issue_rd_wen;
  logic [IW-1:0]   issue_rd_idx, issue_rs1_idx, issue_rs2_idx;
  logic            issue_stall;
  logic [N-1:0]    wb_vld, wb_rdy;
  logic [N*IW-1:0] wb_idx;
  logic [N*XL-1:0] wb_dat;
  logic            rf_wen;
  logic [IW-1:0]   rf_widx;
  logic [XL-1:0]   rf_wdat;

  always #5 clk = ~clk;

  core_wb_sched dut (
    .clk           (clk),
    .rst           (rst),
    .issue_vld     (issue_vld),
    .issue_rd_wen  (issue_rd_wen),
    .issue_rd_idx  (issue_rd_idx),
    .issue_rs1_idx (issue_rs1_idx),
    .issue_rs2_idx (issue_rs2_idx),
    .issue_stall   (issue_stall),
    .wb_vld        (wb_vld),
    .wb_idx        (wb_idx),
    .wb_dat        (wb_dat),
    .wb_rdy        (wb_rdy),
    .rf_wen        (rf_wen),
    .rf_widx       (rf_widx),
    .rf_wdat       (rf_wdat)
  );

  typedef struct {
    int            idx;
    logic [XL-1:0] dat;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  int  obs_g[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  int  mon_cyc     = 0;

  // Reference state: pending registers, next port to favour, write visible now.
  bit  m_pend [NREG];
  int  m_ptr     = 0;
  bit  m_now_v   = 1'b0;
  int  m_now_idx = 0;
  int  last_gnt  = -1;
  bit  rst_prev  = 1'b0;
  bit  hold [N];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, req);
    end
  endfunction

  // Model and per-cycle checks of the combinational outputs.
  always @(negedge clk) begin
    int           gi;
    int           p;
    int           widx;
    logic [N-1:0] er;
    bit           es;
    cyc++;
    gi = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (gi < 0 && wb_vld[p]) gi = p;
      end
    end
    er = '0;
    if (gi >= 0) er[gi] = 1'b1;
    es = !rst && issue_vld &&
         (m_pend[issue_rs1_idx] || m_pend[issue_rs2_idx] ||
          (issue_rd_wen && m_pend[issue_rd_idx]));
    check("wb_rdy", 64'(wb_rdy), 64'(er));
    check("issue_stall", 64'(issue_stall), 64'(es));
    if (rst_prev) begin
      check("rst_rf_wen", 64'(rf_wen), 64'(0));
      check("rst_rf_widx", 64'(rf_widx), 64'(0));
      check("rst_rf_wdat", 64'(rf_wdat), 64'(0));
    end
    for (int k = 0; k < N; k++) if (wb_rdy[k] === 1'b1) obs_g.push_back(k);
    last_gnt = gi;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ptr   = 0;
      m_now_v = 1'b0;
    end else begin
      if (m_now_v) m_pend[m_now_idx] = 1'b0;
      if (issue_vld && !es && issue_rd_wen && issue_rd_idx != '0) m_pend[issue_rd_idx] = 1'b1;
      m_now_v = 1'b0;
      if (gi >= 0) begin
        m_ptr = (gi + 1) % N;
        widx  = int'(wb_idx[gi*IW +: IW]);
        if (widx != 0) begin
          m_now_v   = 1'b1;
          m_now_idx = widx;
          exp_q.push_back('{widx, wb_dat[gi*XL +: XL], cyc});
        end
      end
    end
    rst_prev = rst;
  end

  // Write-port monitor: every rf_wen must match the oldest predicted write, one cycle after it.
  always @(negedge clk) begin
    wr_t e;
    mon_cyc++;
    if (rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rf_write @cycle %0d: got write to x%0d, want no write", mon_cyc, rf_widx);
      end else begin
        e = exp_q.pop_front();
        check("rf_widx", 64'(rf_widx), 64'(e.idx));
        check("rf_wdat", 64'(rf_wdat), 64'(e.dat));
        check("rf_wen_cycle", 64'(mon_cyc), 64'(e.cyc + 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_vld     = 1'b0;
    issue_rd_wen  = 1'b0;
    issue_rd_idx  = '0;
    issue_rs1_idx = '0;
    issue_rs2_idx = '0;
    wb_vld        = '0;
    wb_idx        = '0;
    wb_dat        = '0;
  endtask

  task automatic set_issue(input bit wen, input int rd, input int rs1, input int rs2);
    issue_vld     = 1'b1;
    issue_rd_wen  = wen;
    issue_rd_idx  = IW'(rd);
    issue_rs1_idx = IW'(rs1);
    issue_rs2_idx = IW'(rs2);
  endtask

  task automatic set_wb(input int p, input int idx, input logic [XL-1:0] dat);
    wb_vld[p]             = 1'b1;
    wb_idx[p*IW +: IW]    = IW'(idx);
    wb_dat[p*XL +: XL]    = dat;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) tick();

    // All ports request continuously out of reset.
    rst = 1'b0;
    obs_g.delete();
    for (int p = 0; p < N; p++) set_wb(p, p + 1, XL'(32'h1000 + p));
    repeat (8) tick();
    wb_vld = '0;
    check("grant_count", 64'(obs_g.size() >= 6), 64'(1));
    for (int k = 0; k < 6 && k < obs_g.size(); k++) check("grant_order", 64'(obs_g[k]), 64'(k % N));
    idle();
    repeat (2) tick();

    // RAW on x5, released by a writeback from port 2.
    set_issue(1'b1, 5, 0, 0);
    tick();
    set_issue(1'b0, 0, 5, 0);
    repeat (2) tick();
    set_wb(2, 5, 32'hA5A5_0005);
    tick();
    wb_vld = '0;
    repeat (4) tick();
    idle();

    // x0 writeback is consumed without a regfile write.
    set_wb(1, 0, 32'hDEAD_BEEF);
    tick();
    idle();
    tick();

    // Write to non-pending x7 coinciding with a new issue to x7.
    set_wb(0, 7, 32'h0000_0077);
    tick();
    wb_vld = '0;
    set_issue(1'b1, 7, 0, 0);
    tick();
    set_issue(1'b0, 0, 0, 7);
    repeat (3) tick();
    idle();

    // WAW on x9.
    set_issue(1'b1, 9, 0, 0);
    tick();
    repeat (2) tick();
    set_wb(1, 9, 32'h0000_0909);
    tick();
    wb_vld = '0;
    repeat (3) tick();
    idle();

    // Reset with x3 pending and a request outstanding.
    set_issue(1'b1, 3, 0, 0);
    tick();
    idle();
    set_wb(0, 3, 32'h0000_0033);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs_g.delete();
    for (int p = 0; p < N; p++) set_wb(p, p + 1, XL'(32'h2000 + p));
    set_issue(1'b1, 0, 3, 3);
    tick();
    check("first_grant_after_rst", 64'(obs_g.size() > 0 ? obs_g[0] : -1), 64'(0));
    idle();
    repeat (3) tick();

    // Randomized traffic with occasional resets.
    foreach (hold[p]) hold[p] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(299, 0) == 0);
      for (int p = 0; p < N; p++) begin
        if (last_gnt == p) hold[p] = 1'b0;
        if (!hold[p]) begin
          if ($urandom_range(2, 0) != 0) begin
            hold[p] = 1'b1;
            set_wb(p, int'($urandom_range(7, 0)), XL'($urandom()));
          end else begin
            wb_vld[p] = 1'b0;
          end
        end
      end
      issue_vld     = 1'($urandom_range(1, 0));
      issue_rd_wen  = 1'($urandom_range(1, 0));
      issue_rd_idx  = IW'($urandom_range(7, 0));
      issue_rs1_idx = IW'($urandom_range(7, 0));
      issue_rs2_idx = IW'($urandom_range(7, 0));
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (6) tick();
    check("writes_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
